// File: rtl/sim_run_supervisor_pkg.sv
// Shared types and sizing helpers for the run supervisor.
package sim_run_pkg;

  typedef enum logic [2:0] {LOAD, RUN, DRAIN, HALT, FAIL} run_state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_TIMEOUT  = 3'd1,
    CAUSE_MON_ERR  = 3'd2,
    CAUSE_MEM_ERR  = 3'd3,
    CAUSE_DEADLOCK = 3'd4
  } fail_cause_t;

  localparam int unsigned DEFAULT_CHANNELS = 8;
  localparam int unsigned POP_W = $clog2(DEFAULT_CHANNELS + 1);

  function automatic int unsigned pop_width(input int unsigned channels);
    return $clog2(channels + 1);
  endfunction

  // Width of a down-window counter that counts 0..n-1 (never narrower than 1 bit).
  function automatic int unsigned ctr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_run_supervisor_commit_popcount.sv
// Combinational population count of the per-channel commit strobes.
module commit_popcount
  import sim_run_pkg::*;
#(
  parameter int unsigned CHANNELS = DEFAULT_CHANNELS,
  parameter int unsigned PW       = pop_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] bits,
  output logic [PW-1:0]       count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      count = count + PW'(bits[i]);
    end
  end

endmodule

// File: rtl/sim_run_supervisor.sv
// Run supervisor: halt/timeout/error/deadlock arbitration with cycle and commit counting.
// Optional deadlock watchdog enabled by defining SIM_RUN_SUPERVISOR_DEADLOCK_EN.
module sim_run_supervisor
  import sim_run_pkg::*;
#(
  parameter int unsigned CHANNELS        = DEFAULT_CHANNELS,
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned DRAIN_CYCLES    = 5,
  parameter int unsigned DEADLOCK_CYCLES = 10000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CNT_W-1:0]    timeout_limit,
  input  logic [CHANNELS-1:0] commit_valid,
  input  logic [CHANNELS-1:0] halt,
  input  logic                mon_error,
  input  logic                mem_error,
  output logic                done,
  output logic                pass,
  output logic [2:0]          fail_cause,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [63:0]         commit_count
);

  localparam int unsigned PW      = pop_width(CHANNELS);
  localparam int unsigned DRAIN_W = ctr_width(DRAIN_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST =
      DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  run_state_t         state_q;
  logic [CNT_W-1:0]   limit_q;
  logic [DRAIN_W-1:0] drain_cnt_q;
  logic [PW-1:0]      pop;

  logic               halt_hit;
  logic               timeout_hit;
  logic               error_hit;
  logic               deadlock_hit;
  fail_cause_t        error_cause;
  logic [CNT_W-1:0]   cycle_next;
  logic [64:0]        commit_sum;
  logic [63:0]        commit_next;

  commit_popcount #(
    .CHANNELS(CHANNELS),
    .PW      (PW)
  ) u_popcount (
    .bits (commit_valid),
    .count(pop)
  );

  always_comb begin
    halt_hit    = |(halt & commit_valid);
    timeout_hit = (limit_q != '0) && (cycle_count == limit_q - CNT_ONE);
    error_hit   = mon_error | mem_error;
    error_cause = mon_error ? CAUSE_MON_ERR : CAUSE_MEM_ERR;
    cycle_next  = (&cycle_count) ? cycle_count : cycle_count + CNT_ONE;
    commit_sum  = {1'b0, commit_count} + 65'(pop);
    commit_next = commit_sum[64] ? '1 : commit_sum[63:0];
  end

`ifdef SIM_RUN_SUPERVISOR_DEADLOCK_EN
  localparam int unsigned IDLE_W = ctr_width(DEADLOCK_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST =
      IDLE_W'((DEADLOCK_CYCLES > 0) ? DEADLOCK_CYCLES - 1 : 0);

  logic [IDLE_W-1:0] idle_cnt_q;

  assign deadlock_hit = ~(|commit_valid) && (idle_cnt_q == IDLE_LAST);
`else
  // Parameter stays referenced so both builds share one interface.
  assign deadlock_hit = 1'b0 && (DEADLOCK_CYCLES != 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      limit_q      <= '0;
      drain_cnt_q  <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_cause   <= CAUSE_NONE;
      cycle_count  <= '0;
      commit_count <= '0;
`ifdef SIM_RUN_SUPERVISOR_DEADLOCK_EN
      idle_cnt_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        LOAD: begin
          limit_q <= timeout_limit;
          state_q <= RUN;
        end

        RUN: begin
          cycle_count  <= cycle_next;
          commit_count <= commit_next;
`ifdef SIM_RUN_SUPERVISOR_DEADLOCK_EN
          idle_cnt_q   <= (|commit_valid) ? '0 : idle_cnt_q + IDLE_W'(1);
`endif
          // Exit priority: halt, timeout, monitor/memory error, deadlock.
          if (halt_hit) begin
            state_q    <= HALT;
            done       <= 1'b1;
            pass       <= 1'b1;
            fail_cause <= CAUSE_NONE;
          end else if (timeout_hit) begin
            state_q    <= FAIL;
            done       <= 1'b1;
            fail_cause <= CAUSE_TIMEOUT;
          end else if (error_hit) begin
            fail_cause  <= error_cause;
            drain_cnt_q <= '0;
            if (DRAIN_CYCLES == 0) begin
              state_q <= FAIL;
              done    <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end else if (deadlock_hit) begin
            state_q    <= FAIL;
            done       <= 1'b1;
            fail_cause <= CAUSE_DEADLOCK;
          end
        end

        DRAIN: begin
          cycle_count  <= cycle_next;
          commit_count <= commit_next;
          if (drain_cnt_q == DRAIN_LAST) begin
            state_q <= FAIL;
            done    <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
          end
        end

        HALT, FAIL: begin
          state_q <= state_q;
        end

        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_run_supervisor.sv
// Self-checking bench for sim_run_supervisor: directed table plus randomized runs vs. an event model.
module tb_sim_run_supervisor;

  localparam int CH    = 8;
  localparam int CW    = 32;
  localparam int DR    = 5;
  localparam int DL    = 16;
  localparam int NSTIM = 1100;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] timeout_limit;
  logic [CH-1:0] commit_valid;
  logic [CH-1:0] halt;
  logic          mon_error;
  logic          mem_error;
  logic          done;
  logic          pass;
  logic [2:0]    fail_cause;
  logic [CW-1:0] cycle_count;
  logic [63:0]   commit_count;

  always #5 clk = ~clk;

  sim_run_supervisor #(
    .CHANNELS       (CH),
    .CNT_W          (CW),
    .DRAIN_CYCLES   (DR),
    .DEADLOCK_CYCLES(DL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .timeout_limit(timeout_limit),
    .commit_valid (commit_valid),
    .halt         (halt),
    .mon_error    (mon_error),
    .mem_error    (mem_error),
    .done         (done),
    .pass         (pass),
    .fail_cause   (fail_cause),
    .cycle_count  (cycle_count),
    .commit_count (commit_count)
  );

  typedef struct {
    logic [7:0] cv;
    logic [7:0] hl;
    logic       me;
    logic       xe;
  } cyc_t;

  typedef struct {
    string      name;
    int         limit;
    int         quiet_from;
    int         a_at;
    logic [7:0] a_cv;
    logic [7:0] a_hl;
    logic       a_me;
    logic       a_xe;
    int         b_at;
    logic [7:0] b_cv;
    logic [7:0] b_hl;
    int         exp_t;
    bit         exp_pass;
    int         exp_cause;
    longint     exp_commit;
  } vec_t;

  cyc_t stim [NSTIM];
  vec_t vecs [12];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic fill(input int quiet_from);
    for (int i = 0; i < NSTIM; i++) begin
      stim[i].cv = (i >= quiet_from) ? 8'h00 : 8'h01;
      stim[i].hl = 8'h00;
      stim[i].me = 1'b0;
      stim[i].xe = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    commit_valid = '0;
    halt         = '0;
    mon_error    = 1'b0;
    mem_error    = 1'b0;
  endtask

  // Resets, runs stim[] through RUN, and checks where done rose plus the frozen outputs.
  task automatic run_check(input string name, input int limit, input int exp_t,
                           input bit exp_pass, input int exp_cause,
                           input logic [63:0] exp_commit);
    int got_t;
    got_t = -1;
    rst = 1'b1;
    timeout_limit = limit;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    // The limit must have been captured in LOAD; scramble it afterwards.
    timeout_limit = $urandom;
    for (int k = 0; k < exp_t + 4; k++) begin
      commit_valid = stim[k].cv;
      halt         = stim[k].hl;
      mon_error    = stim[k].me;
      mem_error    = stim[k].xe;
      @(posedge clk); #1;
      if (done === 1'b1 && got_t < 0) got_t = k + 1;
    end
    idle_inputs();
    check({name, " done_cycle"}, 64'(got_t), 64'(exp_t));
    check({name, " pass"}, 64'(pass), 64'(exp_pass));
    check({name, " cause"}, 64'(fail_cause), 64'(exp_cause));
    check({name, " cycle_count"}, 64'(cycle_count), 64'(exp_t));
    check({name, " commit_count"}, commit_count, exp_commit);
  endtask

  // Event-level model: earliest qualifying event wins, ties broken by exit priority.
  task automatic model(input int limit, output int t, output bit p, output int c,
                       output logic [63:0] commits);
    int hi, ei, best;
    hi = -1;
    ei = -1;
    for (int i = 0; i < NSTIM; i++) begin
      if (hi < 0 && (stim[i].hl & stim[i].cv) != 0) hi = i;
      if (ei < 0 && (stim[i].me || stim[i].xe)) ei = i;
    end
    best = 1 << 30;
    t = 0; p = 0; c = 0;
    if (hi >= 0) begin
      best = hi; t = hi + 1; p = 1; c = 0;
    end
    if (limit != 0 && limit - 1 < best) begin
      best = limit - 1; t = limit; p = 0; c = 1;
    end
    if (ei >= 0 && ei < best) begin
      best = ei; t = ei + 1 + DR; p = 0; c = stim[ei].me ? 2 : 3;
    end
`ifdef SIM_RUN_SUPERVISOR_DEADLOCK_EN
    for (int i = DL - 1; i < best; i++) begin
      bit quiet;
      quiet = 1;
      for (int j = i - DL + 1; j <= i; j++) if (stim[j].cv != 0) quiet = 0;
      if (quiet) begin
        best = i; t = i + 1; p = 0; c = 4;
        break;
      end
    end
`endif
    commits = 0;
    for (int i = 0; i < t; i++) commits += 64'($countones(stim[i].cv));
  endtask

  initial begin
    int dl_t, dl_c;
`ifdef SIM_RUN_SUPERVISOR_DEADLOCK_EN
    dl_t = 26;   dl_c = 4;
`else
    dl_t = 1000; dl_c = 1;
`endif
    //        name          lim   quiet a_at a_cv   a_hl   me    xe    b_at b_cv   b_hl   T    p  c  commits
    vecs[0]  = '{"timeout100", 100, 9999, -1, 8'h00, 8'h00, 1'b0, 1'b0, -1, 8'h00, 8'h00, 100, 0, 1, 100};
    vecs[1]  = '{"halt50",     1000, 9999, 50, 8'h0C, 8'h08, 1'b0, 1'b0, -1, 8'h00, 8'h00, 51, 1, 0, 52};
    vecs[2]  = '{"mon_mem20",  1000, 9999, 20, 8'h01, 8'h00, 1'b1, 1'b1, -1, 8'h00, 8'h00, 26, 0, 2, 26};
    vecs[3]  = '{"mem30",      1000, 9999, 30, 8'h01, 8'h00, 1'b0, 1'b1, -1, 8'h00, 8'h00, 36, 0, 3, 36};
    vecs[4]  = '{"deadlock",   1000, 10,   -1, 8'h00, 8'h00, 1'b0, 1'b0, -1, 8'h00, 8'h00, dl_t, 0, dl_c, 10};
    vecs[5]  = '{"halt_gated", 1000, 9999, 6,  8'h08, 8'h08, 1'b0, 1'b1, 5,  8'h00, 8'hFF, 7, 1, 0, 6};
    vecs[6]  = '{"halt_vs_tmo", 40,  9999, 39, 8'h08, 8'h08, 1'b0, 1'b0, -1, 8'h00, 8'h00, 40, 1, 0, 40};
    vecs[7]  = '{"tmo_vs_mon",  40,  9999, 39, 8'h01, 8'h00, 1'b1, 1'b0, -1, 8'h00, 8'h00, 40, 0, 1, 40};
    vecs[8]  = '{"limit_off",   0,   9999, 500, 8'h08, 8'h08, 1'b0, 1'b0, -1, 8'h00, 8'h00, 501, 1, 0, 501};
    vecs[9]  = '{"mon_at0",    1000, 9999, 0,  8'h01, 8'h00, 1'b1, 1'b0, -1, 8'h00, 8'h00, 6, 0, 2, 6};
    vecs[10] = '{"limit1",      1,   9999, -1, 8'h00, 8'h00, 1'b0, 1'b0, -1, 8'h00, 8'h00, 1, 0, 1, 1};
    vecs[11] = '{"drain_halt", 1000, 9999, 10, 8'h01, 8'h00, 1'b1, 1'b0, 12, 8'h08, 8'h08, 16, 0, 2, 16};

    // Reset state
    rst = 1'b1;
    timeout_limit = 32'd50;
    idle_inputs();
    @(posedge clk); #1;
    check("reset done", 64'(done), 0);
    check("reset pass", 64'(pass), 0);
    check("reset cause", 64'(fail_cause), 0);
    check("reset cycle_count", 64'(cycle_count), 0);
    check("reset commit_count", commit_count, 0);

    for (int v = 0; v < 12; v++) begin
      fill(vecs[v].quiet_from);
      if (vecs[v].a_at >= 0) begin
        stim[vecs[v].a_at].cv = vecs[v].a_cv;
        stim[vecs[v].a_at].hl = vecs[v].a_hl;
        stim[vecs[v].a_at].me = vecs[v].a_me;
        stim[vecs[v].a_at].xe = vecs[v].a_xe;
      end
      if (vecs[v].b_at >= 0) begin
        stim[vecs[v].b_at].cv = vecs[v].b_cv;
        stim[vecs[v].b_at].hl = vecs[v].b_hl;
      end
      run_check(vecs[v].name, vecs[v].limit, vecs[v].exp_t, vecs[v].exp_pass,
                vecs[v].exp_cause, 64'(vecs[v].exp_commit));
    end

    // Asynchronous reset while draining, then a fresh run with a new limit.
    fill(9999);
    stim[3].me = 1'b1;
    rst = 1'b1;
    timeout_limit = 32'd1000;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      commit_valid = stim[k].cv;
      mon_error    = stim[k].me;
      @(posedge clk); #1;
    end
    idle_inputs();
    check("drain cause", 64'(fail_cause), 2);
    check("drain done", 64'(done), 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst done", 64'(done), 0);
    check("async_rst cause", 64'(fail_cause), 0);
    check("async_rst cycle_count", 64'(cycle_count), 0);
    check("async_rst commit_count", commit_count, 0);
    fill(9999);
    run_check("resample", 12, 12, 0, 1, 12);

    // Randomized runs against the event model.
    for (int r = 0; r < 25; r++) begin
      int lim, q, qlen, et, ec;
      bit ep;
      logic [63:0] ecm;
      lim  = $urandom_range(300, 20);
      q    = $urandom_range(250, 0);
      qlen = $urandom_range(25, 5);
      for (int i = 0; i < NSTIM; i++) begin
        stim[i].cv = ($urandom_range(3, 0) == 0 || (i >= q && i < q + qlen)) ? 8'h00 : 8'($urandom);
        stim[i].hl = ($urandom_range(119, 0) == 0) ? 8'($urandom) : 8'($urandom) & ~stim[i].cv;
        stim[i].me = ($urandom_range(249, 0) == 0);
        stim[i].xe = ($urandom_range(249, 0) == 0);
      end
      model(lim, et, ep, ec, ecm);
      run_check($sformatf("rand%0d", r), lim, et, ep, ec, ecm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sim_run_supervisor.md
Name: sim_run_supervisor

Overview:
Synthesizable run supervisor for the mp_ooo bench top. It replaces the ad-hoc halt, timeout and error `always` block. Generalises to CHANNELS commit channels and a programmable timeout, and adds commit counting, a fixed error-drain window and a forward-progress (deadlock) watchdog. The bench samples `done`/`pass` to decide between `$finish` and `$fatal`; the supervisor itself has no simulation-only constructs.

Parameters:
- CHANNELS, 8, number of RVFI/monitor commit channels.
- CNT_W, 32, width of cycle and timeout counters.
- DRAIN_CYCLES, 5, cycles held in DRAIN after an error before FAIL.
- DEADLOCK_CYCLES, 10000, max consecutive cycles with no commit before declaring deadlock.

Ports:
- clk  in  1  bench clock.
- rst  in  1  asynchronous, active-high reset.
- timeout_limit  in  CNT_W  cycle budget; sampled once, on the first cycle after reset deasserts.
- commit_valid  in  CHANNELS  per-channel commit strobe.
- halt  in  CHANNELS  per-channel halt indication; only honoured when the same bit of commit_valid is set.
- mon_error  in  1  monitor error, level.
- mem_error  in  1  memory model error, level.
- done  out  1  run finished; sticky.
- pass  out  1  valid with done; 1 = clean halt.
- fail_cause  out  3  0 NONE, 1 TIMEOUT, 2 MON_ERR, 3 MEM_ERR, 4 DEADLOCK.
- cycle_count  out  CNT_W  cycles spent in RUN.
- commit_count  out  64  total committed instructions.

Behaviour:
- Reset (async assert, sync release): state=LOAD; done=0, pass=0, fail_cause=0, cycle_count=0, commit_count=0; drain and idle counters cleared. A reset asserted mid-run aborts immediately; no outputs are retained.
- LOAD (one cycle): latch timeout_limit into limit_q, then go to RUN.
  - limit_q==0 means timeout is disabled.
- RUN, each cycle:
  - cycle_count += 1, saturating at all-ones.
  - commit_count += popcount(commit_valid), saturating.
  - idle_cnt clears when any commit_valid bit is set, otherwise increments.
- Exit from RUN, evaluated in strict priority order, first match wins; all exits are registered (outputs change the cycle after the triggering input):
  1. Any (halt & commit_valid) -> HALT: done=1, pass=1, cause NONE.
  2. limit_q!=0 and cycle_count==limit_q-1 -> FAIL, cause TIMEOUT. done rises exactly limit_q cycles after entering RUN.
  3. mon_error -> DRAIN, cause MON_ERR.
  4. mem_error -> DRAIN, cause MEM_ERR.
  5. idle_cnt==DEADLOCK_CYCLES-1 with no commit this cycle -> FAIL, cause DEADLOCK.
- A halting commit is counted in commit_count in the same cycle it halts.
- DRAIN: fail_cause is already set. Counters keep advancing. Hold for DRAIN_CYCLES cycles, then go to FAIL with done=1, pass=0.
  - Inputs are ignored in DRAIN; a halt during DRAIN does not convert the run to a pass.
- HALT and FAIL are terminal until rst. Counters freeze; done/pass/fail_cause are stable.
- DRAIN_CYCLES==0: the error path goes RUN -> FAIL directly.

Optional Feature:
SIM_RUN_SUPERVISOR_DEADLOCK_EN.
- Defined: the idle counter and DEADLOCK exit exist.
- Undefined: idle counter logic is removed, cause 4 is never produced, and a hang is only caught by TIMEOUT.

Decomposition:
- sim_run_pkg holds:
  - typedef enum logic [2:0] run_state_t {LOAD, RUN, DRAIN, HALT, FAIL};
  - typedef enum logic [2:0] fail_cause_t with the codes above;
  - localparam POP_W = $clog2(CHANNELS+1).
- One sub-module, commit_popcount: parametrised CHANNELS-bit combinational popcount feeding commit_count.

Test Plan:
- timeout_limit=100, commit_valid=8'h01 every cycle, no halt -> done=1, pass=0, cause=1 exactly 100 cycles after RUN; cycle_count=100.
- timeout_limit=1000, at cycle 50 drive commit_valid=8'h0C with halt=8'h08 -> next cycle done=1, pass=1, cause=0; commit_count equals prior total+2.
- mon_error pulsed 1 cycle at cycle 20 -> cause=2 next cycle, done=1/pass=0 at 20+1+5; mem_error simultaneously -> cause stays 2.
- halt=8'hFF with commit_valid=0, then same cycle halt bit 3 valid and mem_error=1 -> ignored first, then HALT wins (pass=1).
- Deadlock enabled, DEADLOCK_CYCLES=16, commits stop at cycle 10 -> cause=4 at cycle 26; with macro undefined -> no failure until timeout.
- rst asserted for 1 cycle while in DRAIN -> all outputs 0 asynchronously; fresh LOAD resamples timeout_limit.
